tone_detector: RTL and testbench

//  Receive side of the speaker square-wave path: measures the half-period of a 1-bit tone.

---
 rtl/tone_pkg.sv | 13 +
 rtl/tone_sync_edge.sv | 34 +++
 rtl/tone_detector.sv | 146 ++++++++++++++
 tb/tb_tone_detector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and defaults for the tone half-period detector.
// Pure declarations; no logic, no latency, no flow control.
package tone_pkg;
  localparam int TONE_CNT_W = 16;
  localparam logic [TONE_CNT_W-1:0] TONE_TIMEOUT  = 16'hFFFF;
  localparam logic [TONE_CNT_W-1:0] TONE_MIN_HALF = 16'd64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } tone_state_e;
endpackage

// File: rtl/tone_sync_edge.sv
// Synchronizes the async tone pin and flags either edge as a one-cycle registered pulse.
// edge_pulse rises SYNC_STAGES+1 cycles after the pin changes; free-running, no backpressure.
module tone_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic tone_in,
  output logic edge_pulse
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tone_in};
    prev_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_pulse = edge_q;
endmodule

// File: rtl/tone_detector.sv
// Measures the half-period of a 1-bit tone; pin-to-pulse latency SYNC_STAGES+2, no backpressure.
// Optional 4-sample averaging of accepted half-periods under macro TONE_AVG_EN.
module tone_detector
  import tone_pkg::*;
#(
  parameter int               CNT_W       = TONE_CNT_W,
  parameter logic [CNT_W-1:0] MIN_HALF    = TONE_MIN_HALF,
  parameter logic [CNT_W-1:0] TIMEOUT     = TONE_TIMEOUT,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             enable,
  input  logic             tone_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             tone_present,
  output logic             glitch_err
);
  logic             edge_pulse;
  tone_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic             period_valid_q, period_valid_d;
  logic             tone_present_q, tone_present_d;
  logic             glitch_err_q, glitch_err_d;

`ifdef TONE_AVG_EN
  logic [CNT_W-1:0] hist_q [4];
  logic [CNT_W-1:0] hist_d [4];
  logic [2:0]       nsamp_q, nsamp_d;
  logic [CNT_W+1:0] sum;
  logic             hist_clr;
`endif

  tone_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .RST        (RST),
    .tone_in    (tone_in),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    state_d        = state_q;
    half_period_d  = half_period_q;
    tone_present_d = tone_present_q;
    period_valid_d = 1'b0;
    glitch_err_d   = 1'b0;
    cnt_inc        = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + 1'b1;
    cnt_d          = edge_pulse ? CNT_W'(1) : cnt_inc;
`ifdef TONE_AVG_EN
    hist_clr = 1'b0;
    hist_d   = hist_q;
    nsamp_d  = nsamp_q;
    sum      = {2'b00, cnt_q} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
`endif
    if (!enable) begin
      state_d        = IDLE;
      cnt_d          = '0;
      tone_present_d = 1'b0;
`ifdef TONE_AVG_EN
      hist_clr = 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_EDGE;
          cnt_d   = '0;
        end
        WAIT_EDGE: begin
          if (edge_pulse) state_d = MEASURE;
        end
        MEASURE: begin
          if (edge_pulse) begin
            if (cnt_q < MIN_HALF) begin
              glitch_err_d = 1'b1;
            end else begin
              tone_present_d = 1'b1;
`ifdef TONE_AVG_EN
              hist_d[0] = cnt_q;
              for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
              nsamp_d = (nsamp_q == 3'd4) ? nsamp_q : nsamp_q + 3'd1;
              // Fourth and later samples since arming: publish the running mean.
              if (nsamp_q >= 3'd3) begin
                half_period_d  = sum[CNT_W+1:2];
                period_valid_d = 1'b1;
              end
`else
              half_period_d  = cnt_q;
              period_valid_d = 1'b1;
`endif
            end
          end else if (cnt_q == TIMEOUT) begin
            state_d        = WAIT_EDGE;
            tone_present_d = 1'b0;
`ifdef TONE_AVG_EN
            hist_clr = 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef TONE_AVG_EN
    if (hist_clr) begin
      for (int i = 0; i < 4; i++) hist_d[i] = '0;
      nsamp_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      tone_present_q <= 1'b0;
      glitch_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      tone_present_q <= tone_present_d;
      glitch_err_q   <= glitch_err_d;
    end
  end

`ifdef TONE_AVG_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      nsamp_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
      nsamp_q <= nsamp_d;
    end
  end
`endif

  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign tone_present = tone_present_q;
  assign glitch_err   = glitch_err_q;
endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector: tone edges driven on falling clock edges.
module tb_tone_detector;
  import tone_pkg::*;

  logic        clk = 1'b0;
  logic        RST;
  logic        enable;
  logic        tone_in;
  logic [15:0] half_period;
  logic        period_valid;
  logic        tone_present;
  logic        glitch_err;

  int vectors     = 0;
  int miscompares = 0;
  int pv_cnt      = 0;
  int gl_cnt      = 0;
  logic [15:0] last_hp = '0;

  tone_detector dut (
    .clk          (clk),
    .RST          (RST),
    .enable       (enable),
    .tone_in      (tone_in),
    .half_period  (half_period),
    .period_valid (period_valid),
    .tone_present (tone_present),
    .glitch_err   (glitch_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled 1ns after the rising edge.
  always @(posedge clk) begin
    #1;
    if (period_valid) begin
      pv_cnt++;
      last_hp = half_period;
    end
    if (glitch_err) gl_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flip();
    tone_in = ~tone_in;
  endtask

  initial begin
    RST = 1'b1; enable = 1'b0; tone_in = 1'b0;
    wait_cyc(3);
    chk("rst_half_period", 32'(half_period), 32'd0);
    chk("rst_period_valid", 32'(period_valid), 32'd0);
    chk("rst_tone_present", 32'(tone_present), 32'd0);
    chk("rst_glitch_err", 32'(glitch_err), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    RST = 1'b0;
    enable = 1'b1;
    wait_cyc(5);
    chk("armed_state", 32'(dut.state_q), 32'(WAIT_EDGE));

`ifdef TONE_AVG_EN
    flip(); wait_cyc(100);
    flip(); wait_cyc(104);
    flip(); wait_cyc(108);
    flip(); wait_cyc(10);
    chk("avg_no_pulse_3", 32'(pv_cnt), 32'd0);
    chk("avg_present_early", 32'(tone_present), 32'd1);
    wait_cyc(102);
    flip(); wait_cyc(10);
    chk("avg_pulse_4", 32'(pv_cnt), 32'd1);
    chk("avg_half_period", 32'(last_hp), 32'd106);
    chk("avg_hp_out", 32'(half_period), 32'd106);
`else
    // Steady 200-cycle tone
    flip(); wait_cyc(200);
    chk("first_edge_no_pulse", 32'(pv_cnt), 32'd0);
    chk("first_edge_absent", 32'(tone_present), 32'd0);
    chk("first_edge_state", 32'(dut.state_q), 32'(MEASURE));
    flip(); wait_cyc(3);
    chk("latency_early", 32'(period_valid), 32'd0);
    wait_cyc(1);
    chk("latency_pulse", 32'(period_valid), 32'd1);
    chk("hp_200", 32'(half_period), 32'd200);
    chk("present_2nd_edge", 32'(tone_present), 32'd1);
    wait_cyc(196);
    flip(); wait_cyc(200);
    flip(); wait_cyc(200);
    chk("steady_pulses", 32'(pv_cnt), 32'd3);
    chk("steady_hp", 32'(last_hp), 32'd200);

    // Glitch: 10-cycle pulse right after an accepted edge
    flip(); wait_cyc(10);
    flip(); wait_cyc(4);
    chk("glitch_pulse", 32'(glitch_err), 32'd1);
    chk("glitch_hp_held", 32'(half_period), 32'd200);
    wait_cyc(6);
    flip(); wait_cyc(200);
    flip(); wait_cyc(200);
    chk("glitch_count", 32'(gl_cnt), 32'd2);
    chk("glitch_pv_count", 32'(pv_cnt), 32'd5);
    chk("glitch_resume_hp", 32'(last_hp), 32'd200);

    // MIN_HALF boundary: 63 rejected, 64 accepted
    flip(); wait_cyc(63);
    flip(); wait_cyc(64);
    flip(); wait_cyc(10);
    chk("min_half_glitch", 32'(gl_cnt), 32'd3);
    chk("min_half_hp", 32'(last_hp), 32'd64);
    chk("min_half_pv", 32'(pv_cnt), 32'd7);

    // Tone stops: timeout after 65535 idle cycles
    wait_cyc(65000);
    chk("pre_timeout_present", 32'(tone_present), 32'd1);
    chk("pre_timeout_state", 32'(dut.state_q), 32'(MEASURE));
    wait_cyc(600);
    chk("timeout_present", 32'(tone_present), 32'd0);
    chk("timeout_state", 32'(dut.state_q), 32'(WAIT_EDGE));
    chk("timeout_no_pulse", 32'(pv_cnt), 32'd7);
    chk("timeout_hp_held", 32'(half_period), 32'd64);

    // 300-cycle tone, then enable dropped mid-half-period
    flip(); wait_cyc(300);
    chk("rearm_first_edge", 32'(pv_cnt), 32'd7);
    flip(); wait_cyc(300);
    chk("hp_300_pv", 32'(pv_cnt), 32'd8);
    chk("hp_300", 32'(last_hp), 32'd300);
    flip(); wait_cyc(100);
    enable = 1'b0;
    wait_cyc(2);
    chk("disable_state", 32'(dut.state_q), 32'(IDLE));
    chk("disable_present", 32'(tone_present), 32'd0);
    wait_cyc(18);
    flip(); wait_cyc(30);
    enable = 1'b1;
    wait_cyc(100);
    chk("disabled_no_pulse", 32'(pv_cnt), 32'd9);
    chk("disabled_hp_held", 32'(half_period), 32'd300);
    chk("reenable_state", 32'(dut.state_q), 32'(WAIT_EDGE));
    flip(); wait_cyc(300);
    chk("reenable_first_edge", 32'(pv_cnt), 32'd9);
    flip(); wait_cyc(300);
    chk("reenable_pv", 32'(pv_cnt), 32'd10);
    chk("reenable_hp", 32'(last_hp), 32'd300);

    // Async reset mid-MEASURE
    #2;
    RST = 1'b1;
    tone_in = 1'b0;
    #1;
    chk("async_rst_hp", 32'(half_period), 32'd0);
    chk("async_rst_present", 32'(tone_present), 32'd0);
    chk("async_rst_pv", 32'(period_valid), 32'd0);
    chk("async_rst_glitch", 32'(glitch_err), 32'd0);
    wait_cyc(2);
    RST = 1'b0;
    wait_cyc(5);
    flip(); wait_cyc(250);
    chk("post_rst_one_edge", 32'(pv_cnt), 32'd10);
    chk("post_rst_hp_zero", 32'(half_period), 32'd0);
    flip(); wait_cyc(250);
    chk("post_rst_two_edges", 32'(pv_cnt), 32'd11);
    chk("post_rst_hp", 32'(last_hp), 32'd250);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
